// File: rtl/channel_group_classifier.sv
// Tags each channel magnitude with a power-of-two group index relative to the tensor maximum.
// Optional per-group histogram output enabled by defining CHANNEL_GROUP_HIST_EN.
`timescale 1ns/1ps
module channel_group_classifier #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 64,
  parameter int NUM_GROUPS = 8,
  parameter int GROUP_W    = $clog2(NUM_GROUPS)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      max_valid,
  output logic                      max_ready,
  input  logic [DATA_WIDTH-1:0]     max_in,
  input  logic                      ch_valid,
  output logic                      ch_ready,
  input  logic [DATA_WIDTH-1:0]     ch_in,
  output logic                      grp_valid,
  input  logic                      grp_ready,
  output logic [GROUP_W-1:0]        grp_idx,
  output logic [$clog2(NUM_CH)-1:0] grp_ch,
`ifdef CHANNEL_GROUP_HIST_EN
  output logic [NUM_GROUPS*($clog2(NUM_CH)+1)-1:0] grp_hist,
`endif
  output logic                      done
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int HIST_W = CH_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] max_q;
  logic [CH_W-1:0]       cnt_q;
  logic [GROUP_W-1:0]    cls_idx;
  logic                  max_hs, ch_hs, out_hs, last_ch;

  assign max_hs  = max_valid & max_ready;
  assign ch_hs   = ch_valid & ch_ready;
  assign out_hs  = grp_valid & grp_ready;
  assign last_ch = (cnt_q == CH_W'(NUM_CH - 1));

  // Parallel threshold compares; the lowest matching k wins.
  always_comb begin
    cls_idx = GROUP_W'(NUM_GROUPS - 1);
    for (int k = NUM_GROUPS - 2; k >= 0; k--) begin
      if (ch_in > (max_q >> (k + 1))) cls_idx = GROUP_W'(k);
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    max_ready = 1'b0;
    ch_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        max_ready = 1'b1;
        if (max_hs) state_d = STREAM;
      end
      STREAM: begin
        ch_ready = !grp_valid | grp_ready;
        if (ch_hs && last_ch) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      max_q     <= '0;
      cnt_q     <= '0;
      grp_valid <= 1'b0;
      grp_idx   <= '0;
      grp_ch    <= '0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == DRAIN) && out_hs;
      if (max_hs) begin
        max_q <= max_in;
        cnt_q <= '0;
      end
      if (ch_hs) begin
        grp_valid <= 1'b1;
        grp_idx   <= cls_idx;
        grp_ch    <= cnt_q;
        cnt_q     <= cnt_q + CH_W'(1);
      end else if (grp_ready) begin
        grp_valid <= 1'b0;
      end
    end
  end

`ifdef CHANNEL_GROUP_HIST_EN
  logic [HIST_W-1:0] hist_q [NUM_GROUPS];

  // NOTE: the histogram is a small counter bank, not a RAM, so it is reset like any other register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int g = 0; g < NUM_GROUPS; g++) hist_q[g] <= '0;
    end else if (max_hs) begin
      for (int g = 0; g < NUM_GROUPS; g++) hist_q[g] <= '0;
    end else if (out_hs) begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        if (grp_idx == GROUP_W'(g)) hist_q[g] <= hist_q[g] + HIST_W'(1);
      end
    end
  end

  always_comb begin
    grp_hist = '0;
    for (int g = 0; g < NUM_GROUPS; g++) grp_hist[g*HIST_W +: HIST_W] = hist_q[g];
  end
`endif

endmodule

// File: tb/tb_channel_group_classifier.sv
// Self-checking bench for channel_group_classifier: directed and randomized tensors against a
// division-based reference model; histogram checks compile in when CHANNEL_GROUP_HIST_EN is defined.
`timescale 1ns/1ps
module tb_channel_group_classifier;

  localparam int DW = 16;
  localparam int NC = 64;
  localparam int NG = 8;
  localparam int GW = 3;
  localparam int CW = 6;
  localparam int HW = CW + 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          max_valid, max_ready;
  logic [DW-1:0] max_in;
  logic          ch_valid, ch_ready;
  logic [DW-1:0] ch_in;
  logic          grp_valid, grp_ready;
  logic [GW-1:0] grp_idx;
  logic [CW-1:0] grp_ch;
  logic          done;
`ifdef CHANNEL_GROUP_HIST_EN
  logic [NG*HW-1:0] grp_hist;
`endif

  always #5 clk = ~clk;

  channel_group_classifier #(
    .DATA_WIDTH(DW), .NUM_CH(NC), .NUM_GROUPS(NG), .GROUP_W(GW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .max_valid(max_valid), .max_ready(max_ready), .max_in(max_in),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_in(ch_in),
    .grp_valid(grp_valid), .grp_ready(grp_ready),
    .grp_idx(grp_idx), .grp_ch(grp_ch),
`ifdef CHANNEL_GROUP_HIST_EN
    .grp_hist(grp_hist),
`endif
    .done(done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] chans [NC];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Group = first k whose threshold max/2^(k+1) the channel exceeds; else the last group.
  function automatic int model(input int mx, input int c);
    for (int k = 0; k < NG - 1; k++) begin
      if (c > mx / (2 ** (k + 1))) return k;
    end
    return NG - 1;
  endfunction

  function automatic logic [DW-1:0] rand_mag();
    return DW'($urandom & 32'hFFFF) >> $urandom_range(0, 15);
  endfunction

  // mode: 0 = grp_ready always high, 1 = toggling, 2 = random.
  // guard keeps max_valid high during the tensor; abort_at >= 0 resets after that many channels.
  task automatic run_tensor(input int mx, input int mode, input bit guard, input int abort_at);
    int  si, ri;
    bit  exp_done, seen_done;
    int  hist_exp [NG];
    for (int g = 0; g < NG; g++) hist_exp[g] = 0;
    si = 0; ri = 0; exp_done = 0; seen_done = 0;

    max_valid = 1'b1;
    max_in    = DW'(mx);
    @(negedge clk);
    check("max_ready_idle", max_ready, 1);
    @(posedge clk); #1;
    max_valid = guard;
    max_in    = rand_mag();

    for (int cyc = 0; cyc < 2000 && !seen_done; cyc++) begin
      ch_valid = (si < NC);
      if (si < NC) ch_in = chans[si];
      else         ch_in = rand_mag();
      case (mode)
        0:       grp_ready = 1'b1;
        1:       grp_ready = (cyc % 2 == 0);
        default: grp_ready = 1'($urandom_range(0, 1));
      endcase
      if (abort_at >= 0 && si == abort_at) begin
        rstn = 1'b0;
        ch_valid = 1'b0;
        max_valid = 1'b0;
        #1;
        check("rst_grp_valid", grp_valid, 0);
        check("rst_grp_idx", grp_idx, 0);
        check("rst_grp_ch", grp_ch, 0);
        check("rst_done", done, 0);
        check("rst_ch_ready", ch_ready, 0);
        check("rst_max_ready", max_ready, 1);
        @(posedge clk); #1;
        rstn = 1'b1;
        return;
      end
      @(negedge clk);
`ifdef CHANNEL_GROUP_HIST_EN
      if (cyc == 0) check("hist_cleared", grp_hist, 0);
`endif
      if (exp_done) begin
        check("done_pulse", done, 1);
        check("done_grp_valid", grp_valid, 0);
        check("done_max_ready", max_ready, 1);
        check("done_ch_ready", ch_ready, 0);
`ifdef CHANNEL_GROUP_HIST_EN
        for (int g = 0; g < NG; g++) check("hist_count", grp_hist[g*HW +: HW], hist_exp[g]);
`endif
        seen_done = 1;
      end else begin
        check("done_low", done, 0);
        check("max_ready_busy", max_ready, 0);
        if (grp_valid) begin
          if (ri >= NC) begin
            check("extra_output", grp_valid, 0);
          end else begin
            check("grp_idx", grp_idx, model(mx, chans[ri]));
            check("grp_ch", grp_ch, ri[CW-1:0]);
          end
          if (!grp_ready) check("ch_ready_stall", ch_ready, 0);
        end
        if (ch_valid && ch_ready) si++;
        if (grp_valid && grp_ready && ri < NC) begin
          hist_exp[model(mx, chans[ri])]++;
          ri++;
          if (ri == NC) exp_done = 1;
        end
      end
      @(posedge clk); #1;
      if (exp_done) max_valid = 1'b0;
    end
    check("tensor_completed", seen_done, 1);
    ch_valid  = 1'b0;
    grp_ready = 1'b0;
    @(negedge clk);
    check("done_single", done, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rstn = 1'b0; max_valid = 1'b0; max_in = '0;
    ch_valid = 1'b0; ch_in = '0; grp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_max_ready", max_ready, 1);
    check("reset_ch_ready", ch_ready, 0);
    check("reset_grp_valid", grp_valid, 0);
    check("reset_grp_idx", grp_idx, 0);
    check("reset_grp_ch", grp_ch, 0);
    check("reset_done", done, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Channel beats while idle are refused.
    ch_valid = 1'b1; ch_in = 16'h0100;
    repeat (4) begin
      @(negedge clk);
      check("idle_ch_ready", ch_ready, 0);
      check("idle_grp_valid", grp_valid, 0);
    end
    @(posedge clk); #1;
    ch_valid = 1'b0;

    // Basic grouping table.
    chans[0] = 16'h0100; chans[1] = 16'h0080; chans[2] = 16'h0081; chans[3] = 16'h0041;
    chans[4] = 16'h0001; chans[5] = 16'h0000; chans[6] = 16'h0200;
    for (int i = 7; i < NC; i++) chans[i] = 16'h0100;
    run_tensor(16'h0100, 0, 0, -1);

    // Backpressure with toggling grp_ready and a held second max beat.
    for (int i = 0; i < NC; i++) chans[i] = rand_mag();
    run_tensor(int'(rand_mag()) | 1, 1, 1, -1);

    // Zero maximum.
    for (int i = 0; i < NC; i++) chans[i] = (i % 2 == 0) ? 16'h0000 : 16'h0005;
    run_tensor(0, 0, 0, -1);

    // Reset after 20 channels, then a fresh tensor restarting at channel 0.
    for (int i = 0; i < NC; i++) chans[i] = rand_mag();
    run_tensor(16'h1234, 0, 0, 20);
    run_tensor(16'h1234, 2, 0, -1);

    // Histogram-shaped tensor.
    for (int i = 0; i < NC; i++) chans[i] = (i < 32) ? 16'hFFFF : (i < 48) ? 16'h7000 : 16'h0000;
    run_tensor(16'hFFFF, 0, 0, -1);

    // Random tensors with random output backpressure.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NC; i++) chans[i] = rand_mag();
      run_tensor(int'(rand_mag()), 2, 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
